// File: rtl/mult_hilo_unit.sv
// Sequential shift-add 32x32 multiplier with HI/LO registers; 33 clocks from start to result.
// start is accepted only in IDLE (ignored while busy); MTHI/MTLO writes apply only when idle.
module mult_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [2*WIDTH:0]   p_q, p_n;
  logic [WIDTH-1:0]   a_q, a_n;
  logic               neg_q, neg_n;
  logic [WIDTH-1:0]   hi_q, hi_n, lo_q, lo_n;
  logic               busy_q, busy_n, done_q, done_n;

  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    p_n     = p_q;
    a_n     = a_q;
    neg_n   = neg_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    done_n  = 1'b0;
    mag_b   = '0;
    prod    = '0;
    // Carry of the high-half add is kept so the logical shift brings it back in.
    add_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    shifted = p_q[0] ? {add_sum, p_q[WIDTH-1:0]} : {1'b0, p_q[2*WIDTH-1:0]};

    case (state_q)
      IDLE: begin
        if (hi_we) hi_n = wdata;
        if (lo_we) lo_n = wdata;
        if (start) begin
          a_n     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
          mag_b   = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
          neg_n   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          p_n     = {{(WIDTH+1){1'b0}}, mag_b};
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        p_n   = {1'b0, shifted[2*WIDTH:1]};
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_n = FIX;
      end
      FIX: begin
        prod    = neg_q ? -p_q[2*WIDTH-1:0] : p_q[2*WIDTH-1:0];
        hi_n    = prod[2*WIDTH-1:WIDTH];
        lo_n    = prod[WIDTH-1:0];
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      p_q     <= p_n;
      a_q     <= a_n;
      neg_q   <= neg_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign result = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: corner products, ignored inputs while busy,
// mid-operation reset, MTHI/MTLO and back-to-back issue.
module tb_mult_hilo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        hilo_sel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo, result;

  int cmp = 0;
  int err = 0;

  mult_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hilo_sel(hilo_sel), .busy(busy), .done(done), .hi(hi), .lo(lo), .result(result)
  );

  always #5 clk = ~clk;

  // Called at a negedge; issues start on the next edge (E0), returns at the negedge after done.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] h, output logic [31:0] l,
                         output int busy_cycles, output int done_edge);
    is_signed = s; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    busy_cycles = 0; done_edge = 0;
    for (int e = 1; e <= 40 && done_edge == 0; e++) begin
      if (busy) busy_cycles++;
      @(posedge clk); @(negedge clk);
      if (done) done_edge = e;
    end
    h = hi; l = lo;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", busy); end
    cmp++; if (done !== 1'b0) begin err++; $display("FAIL reset_done got %b want 0", done); end
    cmp++; if ({hi, lo} !== 64'h0) begin err++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
  endtask

  task automatic test_unsigned();
    logic [31:0] h, l; int bc, de;
    run_mul(32'd7, 32'd6, 1'b0, h, l, bc, de);
    cmp++; if (bc != 33) begin err++; $display("FAIL u7x6_busy_cycles got %0d want 33", bc); end
    cmp++; if (de != 33) begin err++; $display("FAIL u7x6_done_edge got %0d want 33", de); end
    cmp++; if ({h, l} !== 64'h0000_0000_0000_002A) begin err++; $display("FAIL u7x6_prod got %h want 2a", {h, l}); end
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL u7x6_busy_after got %b want 0", busy); end
    hilo_sel = 1'b0; #1;
    cmp++; if (result !== 32'h2A) begin err++; $display("FAIL u7x6_result got %h want 2a", result); end
    @(posedge clk); @(negedge clk);
    cmp++; if (done !== 1'b0) begin err++; $display("FAIL done_single_pulse got %b want 0", done); end
  endtask

  task automatic test_corners();
    logic [31:0] ta [6], tb [6]; logic ts [6]; logic [63:0] tp [6];
    logic [31:0] h, l; int bc, de;
    ta[0] = 32'hFFFFFFFD; tb[0] = 32'd5;        ts[0] = 1; tp[0] = 64'hFFFFFFFF_FFFFFFF1;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'hFFFFFFFF; ts[1] = 0; tp[1] = 64'hFFFFFFFE_00000001;
    ta[2] = 32'h80000000; tb[2] = 32'h80000000; ts[2] = 1; tp[2] = 64'h40000000_00000000;
    ta[3] = 32'h80000000; tb[3] = 32'hFFFFFFFF; ts[3] = 1; tp[3] = 64'h00000000_80000000;
    ta[4] = 32'h00000000; tb[4] = 32'h80000000; ts[4] = 1; tp[4] = 64'h0;
    ta[5] = 32'hFFFFFFFF; tb[5] = 32'hFFFFFFFF; ts[5] = 1; tp[5] = 64'h00000000_00000001;
    for (int i = 0; i < 6; i++) begin
      run_mul(ta[i], tb[i], ts[i], h, l, bc, de);
      cmp++; if ({h, l} !== tp[i] || de != 33)
        begin err++; $display("FAIL corner%0d got %h edge %0d want %h edge 33", i, {h, l}, de, tp[i]); end
    end
  endtask

  task automatic test_ignored_while_busy();
    int dcount = 0, dedge = 0;
    is_signed = 1'b0; op_a = 32'h0001_0000; op_b = 32'h0001_0000; start = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int e = 1; e <= 45; e++) begin
      start = (e == 5);
      op_a  = (e == 5) ? 32'd3 : 32'h0001_0000;
      op_b  = (e == 5) ? 32'd4 : 32'h0001_0000;
      hi_we = (e == 10);
      wdata = (e == 10) ? 32'h1234 : 32'h0;
      @(posedge clk); @(negedge clk);
      if (done) begin dcount++; dedge = e; end
    end
    start = 1'b0; hi_we = 1'b0;
    cmp++; if (dcount != 1) begin err++; $display("FAIL ignore_done_count got %0d want 1", dcount); end
    cmp++; if (dedge != 33) begin err++; $display("FAIL ignore_done_edge got %0d want 33", dedge); end
    cmp++; if ({hi, lo} !== 64'h00000001_00000000) begin err++; $display("FAIL ignore_prod got %h want 100000000", {hi, lo}); end
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL ignore_no_second_op busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int dcount = 0; logic [31:0] h, l; int bc, de;
    is_signed = 1'b0; op_a = 32'd100; op_b = 32'd200; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      rst = (e == 12);
      @(posedge clk); @(negedge clk);
      if (done) dcount++;
    end
    rst = 1'b0;
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    cmp++; if ({hi, lo} !== 64'h0) begin err++; $display("FAIL rstmid_hilo got %h want 0", {hi, lo}); end
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); @(negedge clk);
      if (done) dcount++;
    end
    cmp++; if (dcount != 0) begin err++; $display("FAIL rstmid_no_done got %0d pulses want 0", dcount); end
    run_mul(32'd3, 32'd3, 1'b0, h, l, bc, de);
    cmp++; if (l !== 32'd9 || de != 33) begin err++; $display("FAIL rstmid_3x3 got lo %h edge %0d want 9 edge 33", l, de); end
  endtask

  task automatic test_mthi_mtlo();
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    lo_we = 1'b0;
    hilo_sel = 1'b1; #1;
    cmp++; if (result !== 32'hDEADBEEF) begin err++; $display("FAIL mthi_result got %h want deadbeef", result); end
    hilo_sel = 1'b0; #1;
    cmp++; if (result !== 32'hCAFEF00D) begin err++; $display("FAIL mtlo_result got %h want cafef00d", result); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l; int bc, de;
    run_mul(32'd2, 32'd3, 1'b0, h, l, bc, de);
    cmp++; if (l !== 32'd6 || done !== 1'b1) begin err++; $display("FAIL b2b_first got lo %h done %b want 6 1", l, done); end
    run_mul(32'd4, 32'd5, 1'b0, h, l, bc, de);
    cmp++; if (l !== 32'd20 || de != 33) begin err++; $display("FAIL b2b_second got lo %h edge %0d want 14 edge 33", l, de); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_corners();
    test_ignored_while_busy();
    test_reset_mid();
    test_mthi_mtlo();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
